// File: rtl/bp_mem_resp_delay.sv
// ============================================================================
// Module   : bp_mem_resp_delay
// Purpose  : Latency/backpressure stage between the test memory model and the
//            CCE mem-response inputs. Each of the two response channels is
//            buffered in its own in-order queue. An entry is released to the
//            CCE (valid->yumi) no earlier than delay_p cycles after capture.
// Ports    : clk_i, reset_i           - clock, synchronous active-high reset
//            mem_resp_*_i / _ready_o  - response from memory (ready->valid)
//            mem_data_resp_*_i/_ready_o - data response from memory
//            mem_resp_o / _v_o / _yumi_i           - delayed response to CCE
//            mem_data_resp_o / _v_o / _yumi_i      - delayed data resp to CCE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// One delay channel: circular queue of ELS entries, each carrying a payload
// and a saturating countdown that must reach zero before the head is shown.
// ----------------------------------------------------------------------------
module bp_mem_resp_delay_chan #(
  parameter int WIDTH = 8,
  parameter int ELS   = 2,
  parameter int DELAY = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_v,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_v,
  input  logic             i_yumi
);

  localparam int C_PTR_W = (ELS > 1) ? $clog2(ELS) : 1;
  localparam int C_CNT_W = $clog2(ELS + 1);
  localparam int C_DLY_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(ELS - 1);
  localparam logic [C_CNT_W-1:0] C_FULL     = C_CNT_W'(ELS);
  localparam logic [C_DLY_W-1:0] C_DELAY    = C_DLY_W'(DELAY);

  logic [WIDTH-1:0]   r_mem [ELS];
  logic [C_DLY_W-1:0] r_dly [ELS];
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_CNT_W-1:0] r_count;

  logic               w_ready;
  logic               w_v;
  logic               w_enq;
  logic               w_deq;
  logic [C_PTR_W-1:0] w_rd_ptr_nxt;
  logic [C_PTR_W-1:0] w_wr_ptr_nxt;

  // Handshake outputs are functions of state (and reset) only; there is no
  // full-queue bypass even when the head is being consumed this cycle.
  assign w_ready = !reset_i && (r_count != C_FULL);
  assign w_v     = !reset_i && (r_count != '0) && (r_dly[r_rd_ptr] == '0);
  assign w_enq   = i_v && w_ready;
  assign w_deq   = i_yumi && w_v;

  // Pointers wrap explicitly so ELS need not be a power of two.
  assign w_rd_ptr_nxt = (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_ptr_nxt = (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;

  assign o_ready = w_ready;
  assign o_v     = w_v;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < ELS; i++) begin
        r_dly[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_deq) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Free slots count down too; harmless because a slot's counter is
      // reloaded on the enqueue that makes it live.
      for (int i = 0; i < ELS; i++) begin
        if (w_enq && (r_wr_ptr == C_PTR_W'(i))) begin
          r_dly[i] <= C_DELAY;
        end else if (r_dly[i] != '0) begin
          r_dly[i] <= r_dly[i] - 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind r_count.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Protocol violations: the offending request is dropped / ignored above.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(i_v && !w_ready))
        else $error("%m: enqueue while queue full, input dropped");
      assert (!(i_yumi && !w_v))
        else $error("%m: yumi without valid head, ignored");
    end
  end

endmodule

// ----------------------------------------------------------------------------
// Top: two identical, fully independent channels.
// ----------------------------------------------------------------------------
module bp_mem_resp_delay #(
  parameter int paddr_width_p        = 22,
  parameter int num_lce_p            = 2,
  parameter int lce_assoc_p          = 8,
  parameter int block_size_in_bits_p = 512,
  parameter int els_p                = 2,
  parameter int delay_p              = 0,
  // Message widths; override with the bp_mem_cce_* macro values when the
  // real interface definitions are in scope.
  parameter int resp_width_lp        = 3 + paddr_width_p
                                       + ((num_lce_p > 1) ? $clog2(num_lce_p) : 1)
                                       + ((lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1),
  parameter int data_resp_width_lp   = resp_width_lp + block_size_in_bits_p
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic [resp_width_lp-1:0]      mem_resp_i,
  input  logic                          mem_resp_v_i,
  output logic                          mem_resp_ready_o,

  input  logic [data_resp_width_lp-1:0] mem_data_resp_i,
  input  logic                          mem_data_resp_v_i,
  output logic                          mem_data_resp_ready_o,

  output logic [resp_width_lp-1:0]      mem_resp_o,
  output logic                          mem_resp_v_o,
  input  logic                          mem_resp_yumi_i,

  output logic [data_resp_width_lp-1:0] mem_data_resp_o,
  output logic                          mem_data_resp_v_o,
  input  logic                          mem_data_resp_yumi_i
);

  bp_mem_resp_delay_chan #(
    .WIDTH (resp_width_lp),
    .ELS   (els_p),
    .DELAY (delay_p)
  ) u_resp_chan (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_data  (mem_resp_i),
    .i_v     (mem_resp_v_i),
    .o_ready (mem_resp_ready_o),
    .o_data  (mem_resp_o),
    .o_v     (mem_resp_v_o),
    .i_yumi  (mem_resp_yumi_i)
  );

  bp_mem_resp_delay_chan #(
    .WIDTH (data_resp_width_lp),
    .ELS   (els_p),
    .DELAY (delay_p)
  ) u_data_chan (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_data  (mem_data_resp_i),
    .i_v     (mem_data_resp_v_i),
    .o_ready (mem_data_resp_ready_o),
    .o_data  (mem_data_resp_o),
    .o_v     (mem_data_resp_v_o),
    .i_yumi  (mem_data_resp_yumi_i)
  );

endmodule

`default_nettype wire

// File: tb/tb_bp_mem_resp_delay.sv
// ============================================================================
// Module   : tb_bp_mem_resp_delay
// Purpose  : Self-checking bench for bp_mem_resp_delay. Two instances:
//            A (delay 5, depth 2) and B (delay 0, depth 3). Channel index k:
//            0 = A resp, 1 = A data, 2 = B resp, 3 = B data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_mem_resp_delay;

  localparam int PW    = 22;
  localparam int NL    = 2;
  localparam int AS    = 8;
  localparam int BS    = 64;
  localparam int RW    = 3 + PW + 1 + 3;
  localparam int DW    = RW + BS;
  localparam int DLY_A = 5;
  localparam int ELS_A = 2;
  localparam int DLY_B = 0;
  localparam int ELS_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  logic [3:0]    v_in;
  logic [3:0]    yumi_in;
  logic [DW-1:0] pay_in [4];
  logic [3:0]    out_v;
  logic [3:0]    out_ready;
  logic [RW-1:0] a_resp_o, b_resp_o;
  logic [DW-1:0] a_data_o, b_data_o;

  bp_mem_resp_delay #(
    .paddr_width_p(PW), .num_lce_p(NL), .lce_assoc_p(AS), .block_size_in_bits_p(BS),
    .els_p(ELS_A), .delay_p(DLY_A), .resp_width_lp(RW), .data_resp_width_lp(DW)
  ) u_dut_a (
    .clk_i(clk), .reset_i(rst),
    .mem_resp_i(pay_in[0][RW-1:0]), .mem_resp_v_i(v_in[0]), .mem_resp_ready_o(out_ready[0]),
    .mem_data_resp_i(pay_in[1]), .mem_data_resp_v_i(v_in[1]), .mem_data_resp_ready_o(out_ready[1]),
    .mem_resp_o(a_resp_o), .mem_resp_v_o(out_v[0]), .mem_resp_yumi_i(yumi_in[0]),
    .mem_data_resp_o(a_data_o), .mem_data_resp_v_o(out_v[1]), .mem_data_resp_yumi_i(yumi_in[1])
  );

  bp_mem_resp_delay #(
    .paddr_width_p(PW), .num_lce_p(NL), .lce_assoc_p(AS), .block_size_in_bits_p(BS),
    .els_p(ELS_B), .delay_p(DLY_B), .resp_width_lp(RW), .data_resp_width_lp(DW)
  ) u_dut_b (
    .clk_i(clk), .reset_i(rst),
    .mem_resp_i(pay_in[2][RW-1:0]), .mem_resp_v_i(v_in[2]), .mem_resp_ready_o(out_ready[2]),
    .mem_data_resp_i(pay_in[3]), .mem_data_resp_v_i(v_in[3]), .mem_data_resp_ready_o(out_ready[3]),
    .mem_resp_o(b_resp_o), .mem_resp_v_o(out_v[2]), .mem_resp_yumi_i(yumi_in[2]),
    .mem_data_resp_o(b_data_o), .mem_data_resp_v_o(out_v[3]), .mem_data_resp_yumi_i(yumi_in[3])
  );

  function automatic logic [DW-1:0] dut_pay(int k);
    case (k)
      0:       return DW'(a_resp_o);
      1:       return a_data_o;
      2:       return DW'(b_resp_o);
      default: return b_data_o;
    endcase
  endfunction

  function automatic logic [DW-1:0] rand_pay(int k);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    if (k % 2 == 0) return DW'(r[RW-1:0]);
    return r[DW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: one list of (channel, capture cycle, payload) records.
  // An entry is visible once the current cycle reaches capture + 1 + delay.
  // --------------------------------------------------------------------------
  typedef struct {
    int            ch;
    int            t;
    logic [DW-1:0] pay;
  } ent_t;

  ent_t mq[$];

  function automatic int m_dly(int k);
    return (k < 2) ? DLY_A : DLY_B;
  endfunction

  function automatic int m_els(int k);
    return (k < 2) ? ELS_A : ELS_B;
  endfunction

  function automatic int m_count(int k);
    int n = 0;
    foreach (mq[i]) if (mq[i].ch == k) n++;
    return n;
  endfunction

  function automatic int m_head(int k);
    foreach (mq[i]) if (mq[i].ch == k) return i;
    return -1;
  endfunction

  function automatic bit m_ready(int k);
    return !rst && (m_count(k) != m_els(k));
  endfunction

  function automatic bit m_v(int k);
    int h = m_head(k);
    if (rst || h < 0) return 1'b0;
    return cyc >= mq[h].t + 1 + m_dly(k);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        automatic bit pu = v_in[k] && m_ready(k);
        automatic bit po = yumi_in[k] && m_v(k);
        if (po) mq.delete(m_head(k));
        if (pu) mq.push_back('{ch: k, t: cyc, pay: pay_in[k]});
      end
    end
    cyc <= cyc + 1;
  end

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    v_in = '1;
    yumi_in = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (out_ready !== 4'b0000) begin
        bad++; $display("FAIL reset_ready c=%0d got=%b exp=0000", c, out_ready);
      end
      total++;
      if (out_v !== 4'b0000) begin
        bad++; $display("FAIL reset_v c=%0d got=%b exp=0000", c, out_v);
      end
    end
    v_in = '0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_ready !== 4'b1111) begin
      bad++; $display("FAIL ready_after_reset got=%b exp=1111", out_ready);
    end
    for (int c = 0; c < DLY_A + 3; c++) begin
      @(negedge clk);
      total++;
      if (out_v !== 4'b0000) begin
        bad++; $display("FAIL reset_nothing_queued c=%0d got=%b exp=0000", c, out_v);
      end
    end
  endtask

  task automatic test_zero_delay();
    logic [DW-1:0] p;
    p = rand_pay(3);
    p[PW-1:0] = PW'(32'h40);
    @(negedge clk);
    total++;
    if (out_v[3] !== 1'b0 || out_ready[3] !== 1'b1) begin
      bad++; $display("FAIL zd_idle got v=%b rdy=%b exp v=0 rdy=1", out_v[3], out_ready[3]);
    end
    v_in[3] = 1'b1;
    pay_in[3] = p;
    @(negedge clk);
    v_in[3] = 1'b0;
    total++;
    if (out_v[3] !== 1'b1) begin
      bad++; $display("FAIL zd_valid got=%b exp=1", out_v[3]);
    end
    total++;
    if (dut_pay(3) !== p) begin
      bad++; $display("FAIL zd_data got=%h exp=%h", dut_pay(3), p);
    end
    yumi_in[3] = 1'b1;
    @(negedge clk);
    yumi_in[3] = 1'b0;
    total++;
    if (out_v[3] !== 1'b0) begin
      bad++; $display("FAIL zd_single got=%b exp=0", out_v[3]);
    end
  endtask

  task automatic test_delay();
    logic [DW-1:0] pa, pb, ep;
    bit ev, er;
    pa = rand_pay(1);
    pb = rand_pay(1);
    for (int c = 0; c <= DLY_A + 4; c++) begin
      @(negedge clk);
      ev = (c == 1 + DLY_A) || (c == 2 + DLY_A);
      er = !(c >= 2 && c <= 1 + DLY_A);
      ep = (c == 1 + DLY_A) ? pa : pb;
      total++;
      if (out_v[1] !== ev) begin
        bad++; $display("FAIL delay_v c=%0d got=%b exp=%b", c, out_v[1], ev);
      end
      total++;
      if (out_ready[1] !== er) begin
        bad++; $display("FAIL delay_ready c=%0d got=%b exp=%b", c, out_ready[1], er);
      end
      if (ev) begin
        total++;
        if (dut_pay(1) !== ep) begin
          bad++; $display("FAIL delay_data c=%0d got=%h exp=%h", c, dut_pay(1), ep);
        end
      end
      v_in[1] = (c < 2);
      pay_in[1] = (c == 0) ? pa : pb;
      yumi_in[1] = ev;
    end
    v_in = '0;
    yumi_in = '0;
  endtask

  task automatic test_backpressure();
    localparam int H = 20;
    logic [DW-1:0] pa, pb, ep;
    bit ev, er;
    pa = rand_pay(0);
    pb = rand_pay(0);
    for (int c = 0; c <= 3 + DLY_A + H; c++) begin
      @(negedge clk);
      ev = (c >= 1 + DLY_A) && (c <= 2 + DLY_A + H);
      er = !(c >= 2 && c <= 1 + DLY_A + H);
      ep = (c <= 1 + DLY_A + H) ? pa : pb;
      total++;
      if (out_v[0] !== ev) begin
        bad++; $display("FAIL bp_v c=%0d got=%b exp=%b", c, out_v[0], ev);
      end
      total++;
      if (out_ready[0] !== er) begin
        bad++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, out_ready[0], er);
      end
      if (ev) begin
        total++;
        if (dut_pay(0) !== ep) begin
          bad++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, dut_pay(0), ep);
        end
      end
      v_in[0] = (c < 2);
      pay_in[0] = (c == 0) ? pa : pb;
      yumi_in[0] = (c == 1 + DLY_A + H) || (c == 2 + DLY_A + H);
    end
    v_in = '0;
    yumi_in = '0;
  endtask

  task automatic test_independence();
    localparam int L = DLY_A + 8;
    logic [DW-1:0] pr, pd;
    bit evr, evd;
    pr = rand_pay(0);
    pd = rand_pay(1);
    for (int c = 0; c <= L; c++) begin
      @(negedge clk);
      evr = (c >= 1 + DLY_A);
      evd = (c == 2 + DLY_A);
      total++;
      if (out_v[0] !== evr) begin
        bad++; $display("FAIL indep_resp_v c=%0d got=%b exp=%b", c, out_v[0], evr);
      end
      total++;
      if (out_v[1] !== evd) begin
        bad++; $display("FAIL indep_data_v c=%0d got=%b exp=%b", c, out_v[1], evd);
      end
      if (evr) begin
        total++;
        if (dut_pay(0) !== pr) begin
          bad++; $display("FAIL indep_resp_data c=%0d got=%h exp=%h", c, dut_pay(0), pr);
        end
      end
      if (evd) begin
        total++;
        if (dut_pay(1) !== pd) begin
          bad++; $display("FAIL indep_data_data c=%0d got=%h exp=%h", c, dut_pay(1), pd);
        end
      end
      v_in[0] = (c == 0);
      pay_in[0] = pr;
      v_in[1] = (c == 1);
      pay_in[1] = pd;
      yumi_in[1] = evd;
      yumi_in[0] = (c == L);
    end
    @(negedge clk);
    yumi_in = '0;
    v_in = '0;
    total++;
    if (out_v[1:0] !== 2'b00) begin
      bad++; $display("FAIL indep_drained got=%b exp=00", out_v[1:0]);
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] pc;
    bit ev;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      v_in[1] = (c < 2);
      pay_in[1] = rand_pay(1);
      if (c == 3) rst = 1'b1;
    end
    @(negedge clk);
    total++;
    if (out_v[1] !== 1'b0) begin
      bad++; $display("FAIL mr_v_in_reset got=%b exp=0", out_v[1]);
    end
    rst = 1'b0;
    for (int c = 0; c < DLY_A + 4; c++) begin
      @(negedge clk);
      total++;
      if (out_v[1] !== 1'b0 || out_ready[1] !== 1'b1) begin
        bad++; $display("FAIL mr_flushed c=%0d got v=%b rdy=%b exp v=0 rdy=1", c, out_v[1], out_ready[1]);
      end
    end
    pc = rand_pay(1);
    @(negedge clk);
    v_in[1] = 1'b1;
    pay_in[1] = pc;
    for (int c = 1; c <= DLY_A + 3; c++) begin
      @(negedge clk);
      v_in[1] = 1'b0;
      ev = (c == 1 + DLY_A);
      total++;
      if (out_v[1] !== ev) begin
        bad++; $display("FAIL mr_single_v c=%0d got=%b exp=%b", c, out_v[1], ev);
      end
      if (ev) begin
        total++;
        if (dut_pay(1) !== pc) begin
          bad++; $display("FAIL mr_single_data got=%h exp=%h", dut_pay(1), pc);
        end
      end
      yumi_in[1] = ev;
    end
    yumi_in = '0;
  endtask

  task automatic test_random(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        int h;
        h = m_head(k);
        total++;
        if (out_ready[k] !== m_ready(k)) begin
          bad++; $display("FAIL rand_ready k=%0d c=%0d got=%b exp=%b", k, c, out_ready[k], m_ready(k));
        end
        total++;
        if (out_v[k] !== m_v(k)) begin
          bad++; $display("FAIL rand_v k=%0d c=%0d got=%b exp=%b", k, c, out_v[k], m_v(k));
        end
        if (h >= 0) begin
          total++;
          if (dut_pay(k) !== mq[h].pay) begin
            bad++; $display("FAIL rand_data k=%0d c=%0d got=%h exp=%h", k, c, dut_pay(k), mq[h].pay);
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        v_in[k]    = m_ready(k) && ($urandom_range(0, 1) == 1);
        pay_in[k]  = rand_pay(k);
        yumi_in[k] = m_v(k) && ($urandom_range(0, 3) != 0);
      end
    end
    v_in = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) yumi_in[k] = m_v(k);
    end
    @(negedge clk);
    yumi_in = '0;
    @(negedge clk);
    total++;
    if (out_v !== 4'b0000 || out_ready !== 4'b1111) begin
      bad++; $display("FAIL rand_drain got v=%b rdy=%b exp v=0000 rdy=1111", out_v, out_ready);
    end
  endtask

  initial begin
    v_in = '0;
    yumi_in = '0;
    for (int k = 0; k < 4; k++) pay_in[k] = '0;
    test_reset();
    test_zero_delay();
    test_delay();
    test_backpressure();
    test_independence();
    test_mid_reset();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
